// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: arms on enable, rings on the alarm-minute edge, and handles
// snooze, stop and RTC-invalid freeze. All outputs are registered.
module alarm_ring_ctrl #(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       okmaquina,
    input  logic       tick_1hz,
    input  logic [7:0] time_hh,
    input  logic [7:0] time_mm,
    input  logic [7:0] time_ss,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_en,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       activar_alarma,
    output logic       blink,
    output logic [1:0] ring_state,
    output logic [8:0] secs_left
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StRinging = 2'd2,
        StSnooze  = 2'd3
    } state_e;

    localparam logic [8:0] RingLoad   = 9'(RING_SECONDS);
    localparam logic [8:0] SnoozeLoad = 9'(SNOOZE_SECONDS);

    state_e     state_q, state_d;
    logic [8:0] secs_q, secs_d;
    logic       phase_q, phase_d;
    logic       act_q, act_d;
    logic       blink_q, blink_d;
    logic       match_q, stop_q, snooze_q;

    logic       match, trigger, stop_rise, snooze_rise;
    logic [8:0] secs_dec;

    assign match       = okmaquina && (time_hh == alarm_hh) && (time_mm == alarm_mm)
                         && (time_ss == 8'h00);
    assign trigger     = match && !match_q;
    assign stop_rise   = stop_btn && !stop_q;
    assign snooze_rise = snooze_btn && !snooze_q;
    assign secs_dec    = (secs_q == 9'd0) ? 9'd0 : secs_q - 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            secs_q   <= 9'd0;
            phase_q  <= 1'b0;
            act_q    <= 1'b0;
            blink_q  <= 1'b0;
            match_q  <= 1'b0;
            stop_q   <= 1'b0;
            snooze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            secs_q   <= secs_d;
            phase_q  <= phase_d;
            act_q    <= act_d;
            blink_q  <= blink_d;
            match_q  <= match;
            stop_q   <= stop_btn;
            snooze_q <= snooze_btn;
        end
    end

    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        phase_d = phase_q;
        if (state_q != StIdle && !alarm_en) begin
            state_d = StIdle;
            secs_d  = 9'd0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (alarm_en) state_d = StArmed;
                end
                StArmed: begin
                    if (trigger) begin
                        state_d = StRinging;
                        secs_d  = RingLoad;
                        phase_d = 1'b1;
                    end
                end
                StRinging: begin
                    // An invalid RTC freezes the ring entirely; only disable can leave.
                    if (okmaquina) begin
                        if (stop_rise) begin
                            state_d = StArmed;
                            secs_d  = 9'd0;
                            phase_d = 1'b0;
                        end else if (snooze_rise) begin
                            state_d = StSnooze;
                            secs_d  = SnoozeLoad;
                            phase_d = 1'b0;
                        end else if (tick_1hz) begin
                            if (secs_q == 9'd1) begin
                                state_d = StArmed;
                                secs_d  = 9'd0;
                                phase_d = 1'b0;
                            end else begin
                                secs_d  = secs_dec;
                                phase_d = ~phase_q;
                            end
                        end
                    end
                end
                StSnooze: begin
                    if (okmaquina) begin
                        if (stop_rise) begin
                            state_d = StArmed;
                            secs_d  = 9'd0;
                            phase_d = 1'b0;
                        end else if (tick_1hz) begin
                            if (secs_q == 9'd1) begin
                                state_d = StRinging;
                                secs_d  = RingLoad;
                                phase_d = 1'b1;
                            end else begin
                                secs_d = secs_dec;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are computed from the next state so they land on the same edge as the state.
    always_comb begin
        act_d   = (state_d == StRinging) && okmaquina;
        blink_d = act_d && phase_d;
    end

    assign activar_alarma = act_q;
    assign blink          = blink_q;
    assign ring_state     = state_q;
    assign secs_left      = secs_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed alarm scenarios followed by random stimulus, all
// compared against a behavioural model of the ring rules.
module tb_alarm_ring_ctrl;

    localparam int RING   = 3;
    localparam int SNOOZE = 2;
    localparam int IDLE = 0, ARMED = 1, RINGING = 2, SNOOZING = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       okmaquina = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [7:0] time_hh = 8'h00, time_mm = 8'h00, time_ss = 8'h00;
    logic [7:0] alarm_hh = 8'h07, alarm_mm = 8'h30;
    logic       alarm_en = 1'b0, stop_btn = 1'b0, snooze_btn = 1'b0;
    logic       activar_alarma, blink;
    logic [1:0] ring_state;
    logic [8:0] secs_left;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: what the alarm is doing and what the outputs should read.
    int m_state = IDLE, m_secs = 0;
    bit m_phase = 0, m_act = 0, m_blink = 0;
    bit m_match_prev = 0, m_stop_prev = 0, m_snz_prev = 0;

    alarm_ring_ctrl #(
        .RING_SECONDS  (RING),
        .SNOOZE_SECONDS(SNOOZE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .okmaquina     (okmaquina),
        .tick_1hz      (tick_1hz),
        .time_hh       (time_hh),
        .time_mm       (time_mm),
        .time_ss       (time_ss),
        .alarm_hh      (alarm_hh),
        .alarm_mm      (alarm_mm),
        .alarm_en      (alarm_en),
        .stop_btn      (stop_btn),
        .snooze_btn    (snooze_btn),
        .activar_alarma(activar_alarma),
        .blink         (blink),
        .ring_state    (ring_state),
        .secs_left     (secs_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic go_to(input int st, input int secs, input bit ph);
        m_state = st;
        m_secs  = secs;
        m_phase = ph;
    endtask

    task automatic model_step();
        bit match, trig, stop_r, snz_r;
        match  = okmaquina && time_hh == alarm_hh && time_mm == alarm_mm && time_ss == 8'h00;
        trig   = match && !m_match_prev;
        stop_r = stop_btn && !m_stop_prev;
        snz_r  = snooze_btn && !m_snz_prev;
        if (reset) begin
            go_to(IDLE, 0, 0);
            m_match_prev = 0;
            m_stop_prev  = 0;
            m_snz_prev   = 0;
        end else begin
            if (m_state != IDLE && !alarm_en) go_to(IDLE, 0, 0);
            else if (m_state == IDLE) begin
                if (alarm_en) m_state = ARMED;
            end else if (m_state == ARMED) begin
                if (trig) go_to(RINGING, RING, 1);
            end else if (okmaquina) begin
                if (stop_r) go_to(ARMED, 0, 0);
                else if (m_state == RINGING && snz_r) go_to(SNOOZING, SNOOZE, 0);
                else if (tick_1hz && m_secs == 1)
                    go_to(m_state == RINGING ? ARMED : RINGING,
                          m_state == RINGING ? 0 : RING, m_state != RINGING);
                else if (tick_1hz) begin
                    if (m_secs > 0) m_secs--;
                    if (m_state == RINGING) m_phase = !m_phase;
                end
            end
            m_match_prev = match;
            m_stop_prev  = stop_btn;
            m_snz_prev   = snooze_btn;
        end
        m_act   = (m_state == RINGING) && okmaquina;
        m_blink = m_act && m_phase;
    endtask

    // One clock: inputs are already stable; advance model, clock the DUT, compare.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("ring_state", int'(ring_state), m_state);
        check("secs_left", int'(secs_left), m_secs);
        check("activar_alarma", int'(activar_alarma), int'(m_act));
        check("blink", int'(blink), int'(m_blink));
        @(negedge clk);
    endtask

    task automatic set_time(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        time_hh = hh;
        time_mm = mm;
        time_ss = ss;
    endtask

    task automatic ring_now();
        set_time(8'h07, 8'h29, 8'h59);
        step();
        set_time(8'h07, 8'h30, 8'h00);
        step();
    endtask

    task automatic press(input bit stop, input bit snz);
        stop_btn   = stop;
        snooze_btn = snz;
        step();
        stop_btn   = 0;
        snooze_btn = 0;
        step();
    endtask

    task automatic tick_once();
        tick_1hz = 1;
        step();
        tick_1hz = 0;
    endtask

    initial begin
        @(negedge clk);
        step();
        step();
        check("rst_state", int'(ring_state), 0);
        check("rst_act", int'(activar_alarma), 0);
        check("rst_secs", int'(secs_left), 0);
        check("rst_blink", int'(blink), 0);
        reset = 0;
        alarm_en = 1;
        set_time(8'h07, 8'h29, 8'h58);
        step();
        check("armed", int'(ring_state), 1);

        ring_now();
        check("trig_state", int'(ring_state), 2);
        check("trig_act", int'(activar_alarma), 1);
        check("trig_secs", int'(secs_left), 3);
        check("trig_blink", int'(blink), 1);
        tick_once();
        check("tick1_secs", int'(secs_left), 2);
        check("tick1_blink", int'(blink), 0);
        tick_once();
        check("tick2_secs", int'(secs_left), 1);
        tick_once();
        check("expire_state", int'(ring_state), 1);
        check("expire_act", int'(activar_alarma), 0);
        step();
        check("no_retrig_same_min", int'(ring_state), 1);
        set_time(8'h07, 8'h30, 8'h01);
        step();
        check("no_retrig_01", int'(ring_state), 1);

        ring_now();
        press(0, 1);
        check("snooze_state", int'(ring_state), 3);
        check("snooze_secs", int'(secs_left), 2);
        check("snooze_act", int'(activar_alarma), 0);
        tick_once();
        tick_once();
        check("resnooze_state", int'(ring_state), 2);
        check("resnooze_secs", int'(secs_left), 3);
        press(1, 0);
        check("stop_state", int'(ring_state), 1);

        ring_now();
        press(1, 1);
        check("both_btn_state", int'(ring_state), 1);

        ring_now();
        alarm_en = 0;
        stop_btn = 1;
        step();
        check("disable_state", int'(ring_state), 0);
        stop_btn = 0;
        alarm_en = 1;
        step();

        ring_now();
        okmaquina = 0;
        tick_once();
        tick_once();
        check("nok_act", int'(activar_alarma), 0);
        check("nok_secs", int'(secs_left), 3);
        check("nok_state", int'(ring_state), 2);
        okmaquina = 1;
        step();
        check("resume_act", int'(activar_alarma), 1);
        reset = 1;
        step();
        check("midring_rst_state", int'(ring_state), 0);
        check("midring_rst_act", int'(activar_alarma), 0);
        reset = 0;

        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(0, 29) == 0) okmaquina = ~okmaquina;
            if ($urandom_range(0, 7) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 5) == 0) snooze_btn = ~snooze_btn;
            tick_1hz = ($urandom_range(0, 3) == 0);
            time_hh  = ($urandom_range(0, 7) == 0) ? 8'h08 : 8'h07;
            time_mm  = ($urandom_range(0, 7) == 0) ? 8'h31 : 8'h30;
            case ($urandom_range(0, 3))
                0: time_ss = 8'h00;
                1: time_ss = 8'h01;
                2: time_ss = 8'h59;
                default: time_ss = 8'h00;
            endcase
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 Parameter RING_SECONDS, default 60, ring duration in 1 Hz ticks; legal range 1..511.
REQ-002 Parameter SNOOZE_SECONDS, default 300, snooze duration in 1 Hz ticks; legal range 1..511.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 okmaquina  input  1  RTC machine initialised and time valid.
REQ-006 tick_1hz  input  1  one-clk pulse per second, aligned with RTC seconds update.
REQ-007 time_hh, time_mm, time_ss  input  8 each  current time, packed BCD.
REQ-008 alarm_hh, alarm_mm  input  8 each  programmed alarm time, packed BCD.
REQ-009 alarm_en  input  1  alarm enabled (level).
REQ-010 stop_btn  input  1  debounced stop button (level).
REQ-011 snooze_btn  input  1  debounced snooze button (level).
REQ-012 activar_alarma  output  1  ring request to the VGA bell overlay, registered.
REQ-013 blink  output  1  1 Hz blink phase while ringing, registered.
REQ-014 ring_state  output  2  current FSM state: 0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZE.
REQ-015 secs_left  output  9  remaining seconds of current RINGING/SNOOZE interval.

Function
REQ-016 match = okmaquina && time_hh==alarm_hh && time_mm==alarm_mm && time_ss==8'h00; match registered into match_d each clk.
REQ-017 trigger = match && !match_d (rising edge only; one trigger per alarm minute).
REQ-018 stop_rise/snooze_rise = input high this clk, low previous clk (edge-detect registers).
REQ-019 IDLE: alarm_en=1 -> ARMED next clk; all outputs 0.
REQ-020 ARMED: trigger -> RINGING, secs_left <= RING_SECONDS, blink <= 1.
REQ-021 RINGING: activar_alarma=1; each tick_1hz: secs_left decrements by 1 and blink toggles.
REQ-022 RINGING: tick_1hz with secs_left==1 -> ARMED, secs_left <= 0, blink <= 0.
REQ-023 RINGING: snooze_rise -> SNOOZE, secs_left <= SNOOZE_SECONDS, blink <= 0.
REQ-024 RINGING/SNOOZE: stop_rise -> ARMED, secs_left <= 0, blink <= 0.
REQ-025 SNOOZE: activar_alarma=0; each tick_1hz decrements secs_left; tick with secs_left==1 -> RINGING, secs_left <= RING_SECONDS, blink <= 1.
REQ-026 Any state except IDLE: alarm_en=0 -> IDLE, secs_left <= 0, blink <= 0, activar_alarma <= 0 next clk.
REQ-027 Same-clk priority: alarm_en=0 > stop_rise > snooze_rise > tick expiry/decrement > trigger.
REQ-028 okmaquina=0 in RINGING/SNOOZE: activar_alarma forced 0, blink forced 0, state and counter frozen (ticks ignored); resume when okmaquina=1.
REQ-029 Buttons already high when entering RINGING do not act until released and pressed again.
REQ-030 activar_alarma = (state==RINGING) && okmaquina, registered; asserts first clk after trigger edge.
REQ-031 secs_left never wraps below 0; decrement at 0 is a no-op.

Reset
REQ-032 reset=1 at clk edge: state IDLE, activar_alarma 0, blink 0, secs_left 0, match_d/button-edge registers 0; overrides all other inputs, valid mid-ring.

Verification (RING_SECONDS=3, SNOOZE_SECONDS=2)
REQ-033 alarm 07:30, en=1, time steps 07:29:59 -> 07:30:00 -> state RINGING, activar_alarma=1, secs_left=3 one clk later.
REQ-034 Ringing, 3 ticks no buttons -> secs_left 2,1, then ARMED, activar_alarma=0; time 07:30:01.. causes no retrigger.
REQ-035 Ringing, snooze press -> SNOOZE secs_left=2, activar_alarma=0; 2 ticks -> RINGING secs_left=3; stop press -> ARMED.
REQ-036 Ringing, stop_rise and snooze_rise same clk -> ARMED; alarm_en=0 plus stop same clk -> IDLE.
REQ-037 okmaquina=0 during ring for 2 ticks -> activar_alarma=0, secs_left unchanged; reset asserted mid-ring -> all outputs 0, IDLE.
